// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction fetch controller that sits between the PC register and the
// instruction bus. It takes one PC sample per fetch, issues a single bus read
// for it, and holds the returned word for the decode stage until decode
// accepts it. On acceptance it pulses pc_enable so the PC steps or loads a
// branch target. A flush abandons the current fetch. A bus read that is
// already in flight is still allowed to complete, and its data is then
// thrown away.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   pc_in[31:0]   in   current PC from the PC register
//   pc_enable     out  PC advance/load strobe (combinational)
//   flush         in   discard current fetch; PC loads on the same cycle
//   ibus_req      out  instruction bus read request
//   ibus_addr     out  read address, stable while ibus_req=1
//   ibus_ack      in   read complete, ibus_rdata valid this cycle
//   ibus_rdata    in   read data
//   inst_valid    out  inst/inst_pc/inst_addr_err valid to decode
//   inst_ready    in   decode accepts this cycle
//   inst          out  fetched instruction
//   inst_pc       out  address of inst
//   inst_addr_err out  fetch address was misaligned
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic        pc_enable,
    input  logic        flush,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_addr_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_ibus_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_addr_err;

    logic        w_misaligned;
    logic        w_handoff;
    logic        w_sample_pc;
    logic        w_capture;

    assign w_misaligned = (pc_in[1:0] != 2'b00);
    assign w_handoff    = (r_state == ST_HOLD) & inst_ready & ~flush;
    assign w_sample_pc  = (r_state == ST_IDLE) & ~flush;
    // A flush in the ack cycle wins: the word is dropped, not captured.
    assign w_capture    = (r_state == ST_REQ) & ibus_ack & ~flush;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!flush) begin
                    // Misaligned PCs never reach the bus; they go straight
                    // to HOLD carrying a NOP and the error flag.
                    w_state_next = w_misaligned ? ST_HOLD : ST_REQ;
                end
            end
            ST_REQ: begin
                if (ibus_ack) begin
                    w_state_next = flush ? ST_IDLE : ST_HOLD;
                end else if (flush) begin
                    // The read cannot be cancelled; wait for its ack.
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (ibus_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush || inst_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_ibus_addr     <= 32'h0;
            r_inst          <= 32'h0;
            r_inst_pc       <= 32'h0;
            r_inst_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_sample_pc) begin
                r_inst_pc       <= pc_in;
                r_inst_addr_err <= w_misaligned;
                if (w_misaligned) begin
                    r_inst <= NOP_INSTR;
                end else begin
                    r_ibus_addr <= pc_in;
                end
            end
            if (w_capture) begin
                r_inst <= ibus_rdata;
            end
        end
    end

    // Request is a pure function of the registered state, so it cannot
    // glitch on ack or flush and stays up until the ack arrives.
    assign ibus_req      = (r_state == ST_REQ) | (r_state == ST_DISCARD);
    assign ibus_addr     = r_ibus_addr;
    assign inst_valid    = (r_state == ST_HOLD);
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign inst_addr_err = r_inst_addr_err;

    // Flush also strobes the PC so the redirect target loads that cycle.
    assign pc_enable     = w_handoff | flush;

endmodule
